// File: rtl/sseg_scan_ctrl.sv
// rtl/sseg_scan_ctrl.sv - four-digit multiplexed seven-segment scan controller
//
// Purpose: time-multiplexes four active-low segment patterns onto one shared
// segment bus. Each digit owns a slot of 2**REFRESH_POWER clocks. The first
// BLANK_CYCLES clocks of each slot are dark to avoid ghosting. The lit window
// is further shortened by a 4-bit brightness level. Pattern and brightness
// inputs are sampled once per frame (four slots), so a frame never tears.
//
// Ports:
//   clk        - clock, all state updates on its rising edge
//   reset      - synchronous, active-high reset
//   enable     - 1 = display lit per schedule, 0 = dark (timing keeps running)
//   in0..in3   - active-low segment patterns for digits 0..3
//   duty       - brightness, 0 = 1/16 of a slot, 15 = full slot
//   an         - registered active-low digit enables, an[k] drives digit k
//   sseg       - registered active-low segment pattern of the selected digit
//   frame_tick - registered one-cycle pulse at the start of each frame

module sseg_scan_ctrl #(
  parameter int REFRESH_POWER = 18,
  parameter int BLANK_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [3:0] duty,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  localparam logic [REFRESH_POWER-1:0] CNT_MAX     = {REFRESH_POWER{1'b1}};
  localparam logic [REFRESH_POWER-1:0] BLANK_START = REFRESH_POWER'(BLANK_CYCLES);

  logic [REFRESH_POWER-1:0] cnt;
  logic [1:0]               idx;
  logic [7:0]               sh0, sh1, sh2, sh3;
  logic [3:0]               duty_s;

  logic       slot_end;
  logic       frame_end;
  logic       lit;
  logic [7:0] sh_sel;
  logic [3:0] an_nxt;
  logic [7:0] sseg_nxt;

  assign slot_end  = (cnt == CNT_MAX);
  assign frame_end = slot_end && (idx == 2'd3);

  // The top nibble of cnt is the sixteenth of the slot we are in, so it
  // compares directly against the brightness level.
  assign lit = enable && (cnt >= BLANK_START)
                      && (cnt[REFRESH_POWER-1:REFRESH_POWER-4] <= duty_s);

  always_comb begin
    sh_sel = 8'hFF;
    case (idx)
      2'd0:    sh_sel = sh0;
      2'd1:    sh_sel = sh1;
      2'd2:    sh_sel = sh2;
      default: sh_sel = sh3;
    endcase
  end

  always_comb begin
    an_nxt   = 4'b1111;
    sseg_nxt = 8'hFF;
    if (lit) begin
      an_nxt[idx] = 1'b0;
      sseg_nxt    = sh_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= 2'd0;
      sh0        <= 8'hFF;
      sh1        <= 8'hFF;
      sh2        <= 8'hFF;
      sh3        <= 8'hFF;
      duty_s     <= 4'hF;
      an         <= 4'b1111;
      sseg       <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt + 1'b1;
      an         <= an_nxt;
      sseg       <= sseg_nxt;
      frame_tick <= frame_end;
      if (slot_end) begin
        idx <= idx + 2'd1;
      end
      // Shadows load only at the frame boundary so a whole frame shows one
      // consistent set of patterns and brightness.
      if (frame_end) begin
        sh0    <= in0;
        sh1    <= in1;
        sh2    <= in2;
        sh3    <= in3;
        duty_s <= duty;
      end
    end
  end

endmodule
